// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequencing blocks: FSM state encoding and
// default datapath dimensions.
package lstm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_EMIT = 2'd3
    } state_e;

    localparam int DEF_M           = 16;
    localparam int DEF_N           = 32;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_FRACT_WIDTH = 8;

endpackage

// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer wrapped around the LSTM cell. It accepts one feature
// column per timestep, holds the cell inputs stable while the cell computes,
// captures the new hidden/cell state as recurrent feedback and hands each
// h_t downstream. Data is passed through bit-exact.
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int M           = DEF_M,
    parameter int N           = DEF_N,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter int T_MAX       = 64,
    parameter int T_W         = $clog2(T_MAX + 1),
    parameter int CELL_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [T_W-1:0]          seq_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_xt,
    output logic [N*DATA_WIDTH-1:0] cell_xt,
    output logic [M*DATA_WIDTH-1:0] cell_ht,
    output logic [M*DATA_WIDTH-1:0] cell_ct,
    input  logic [M*DATA_WIDTH-1:0] cell_h,
    input  logic [M*DATA_WIDTH-1:0] cell_c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [M*DATA_WIDTH-1:0] out_ht,
    output logic [T_W-1:0]          out_t,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    // The lat counter must reach CELL_LAT, so it needs one value more than
    // the latency itself.
    localparam int LAT_W = (CELL_LAT < 1) ? 1 : $clog2(CELL_LAT + 1);

    if (CELL_LAT < 1) begin : g_bad_cell_lat
        $error("lstm_seq_ctrl: CELL_LAT must be at least 1");
    end
    if (FRACT_WIDTH > DATA_WIDTH) begin : g_bad_fract
        $error("lstm_seq_ctrl: FRACT_WIDTH cannot exceed DATA_WIDTH");
    end

    state_e                  state_q,  state_d;
    logic [T_W-1:0]          len_q,    len_d;
    logic [T_W-1:0]          t_q,      t_d;
    logic [LAT_W-1:0]        lat_q,    lat_d;
    logic [N*DATA_WIDTH-1:0] xt_q,     xt_d;
    logic [M*DATA_WIDTH-1:0] h_q,      h_d;
    logic [M*DATA_WIDTH-1:0] c_q,      c_d;
    logic [M*DATA_WIDTH-1:0] out_ht_q, out_ht_d;
    logic                    done_q,   done_d;
    logic                    is_last;

    assign is_last = (t_q == (len_q - T_W'(1)));

    // State and datapath registers; reset clears everything so every output
    // comes up as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            t_q      <= '0;
            lat_q    <= '0;
            xt_q     <= '0;
            h_q      <= '0;
            c_q      <= '0;
            out_ht_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            t_q      <= t_d;
            lat_q    <= lat_d;
            xt_q     <= xt_d;
            h_q      <= h_d;
            c_q      <= c_d;
            out_ht_q <= out_ht_d;
            done_q   <= done_d;
        end
    end

    // Next-state and output decode. The cell output is sampled once lat has
    // counted CELL_LAT cycles past the first RUN cycle, which is when the
    // cell's last register stage reflects the inputs held since LOAD.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        t_d       = t_q;
        lat_d     = lat_q;
        xt_d      = xt_q;
        h_d       = h_q;
        c_d       = c_q;
        out_ht_d  = out_ht_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (seq_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = (seq_len > T_W'(T_MAX)) ? T_W'(T_MAX) : seq_len;
                        t_d     = '0;
                        h_d     = '0;
                        c_d     = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    xt_d    = in_xt;
                    lat_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lat_d = lat_q + LAT_W'(1);
                if (lat_q == LAT_W'(CELL_LAT)) begin
                    h_d      = cell_h;
                    c_d      = cell_c;
                    out_ht_d = cell_h;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_last  = is_last;
                if (out_ready) begin
                    if (is_last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        t_d     = t_q + T_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cell_xt = xt_q;
    assign cell_ht = h_q;
    assign cell_ct = c_q;
    assign out_ht  = out_ht_q;
    assign out_t   = t_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Testbench for lstm_seq_ctrl with a behavioural pipelined LSTM cell
// stand-in and a lane-level reference model of the recurrence.
module tb_lstm_seq_ctrl;

    localparam int M        = 16;
    localparam int N        = 32;
    localparam int DW       = 16;
    localparam int FW       = 8;
    localparam int T_MAX    = 64;
    localparam int T_W      = $clog2(T_MAX + 1);
    localparam int CELL_LAT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [T_W-1:0]  seqLen;
    logic            inValid;
    logic            inReady;
    logic [N*DW-1:0] inXt;
    logic [N*DW-1:0] cellXt;
    logic [M*DW-1:0] cellHt;
    logic [M*DW-1:0] cellCt;
    logic [M*DW-1:0] cellH;
    logic [M*DW-1:0] cellC;
    logic            outValid;
    logic            outReady;
    logic [M*DW-1:0] outHt;
    logic [T_W-1:0]  outT;
    logic            outLast;
    logic            busy;
    logic            done;

    int assertCount = 0;
    int failCount   = 0;

    // Reference recurrent state, one entry per hidden lane.
    logic [DW-1:0] hModel [M];
    int            cModel;

    // Behavioural cell: CELL_LAT register stages, h = xt[0..M-1] + ht, c = ct + 1.
    logic [M*DW-1:0] pipeH [CELL_LAT];
    logic [M*DW-1:0] pipeC [CELL_LAT];

    lstm_seq_ctrl #(
        .M(M), .N(N), .DATA_WIDTH(DW), .FRACT_WIDTH(FW),
        .T_MAX(T_MAX), .T_W(T_W), .CELL_LAT(CELL_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seq_len(seqLen),
        .in_valid(inValid), .in_ready(inReady), .in_xt(inXt),
        .cell_xt(cellXt), .cell_ht(cellHt), .cell_ct(cellCt),
        .cell_h(cellH), .cell_c(cellC),
        .out_valid(outValid), .out_ready(outReady), .out_ht(outHt),
        .out_t(outT), .out_last(outLast), .busy(busy), .done(done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cell stand-in pipeline.
    always @(posedge clk) begin
        for (int i = 0; i < M; i++) begin
            pipeH[0][i*DW +: DW] <= cellXt[i*DW +: DW] + cellHt[i*DW +: DW];
            pipeC[0][i*DW +: DW] <= cellCt[i*DW +: DW] + DW'(1);
        end
        for (int k = 1; k < CELL_LAT; k++) begin
            pipeH[k] <= pipeH[k-1];
            pipeC[k] <= pipeC[k-1];
        end
    end

    assign cellH = pipeH[CELL_LAT-1];
    assign cellC = pipeC[CELL_LAT-1];

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] actual,
                               input logic [511:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [M*DW-1:0] packHidden();
        logic [M*DW-1:0] v;
        for (int i = 0; i < M; i++) v[i*DW +: DW] = hModel[i];
        return v;
    endfunction

    function automatic logic [M*DW-1:0] fillLanes(input int value);
        logic [M*DW-1:0] v;
        for (int i = 0; i < M; i++) v[i*DW +: DW] = DW'(value);
        return v;
    endfunction

    task automatic checkEmit(input int t, input int effLen);
        checkOutput("emitValid", 512'(outValid), 512'(1));
        checkOutput("emitHt", 512'(outHt), 512'(packHidden()));
        checkOutput("emitT", 512'(outT), 512'(t));
        checkOutput("emitLast", 512'(outLast), 512'(t == effLen - 1));
        checkOutput("emitInReady", 512'(inReady), 512'(0));
    endtask

    // Runs one sequence. pattern 1 makes every xt element t+1, otherwise
    // random. stall<0 picks a random EMIT back-pressure per step. abortT
    // selects the timestep whose RUN phase is hit by a reset. pokeStart
    // pulses start with a different length while the block is busy.
    task automatic applyStimulus(input int len, input int pattern, input int stall,
                                 input int abortT, input bit pokeStart);
        int              effLen;
        int              gap;
        int              stallN;
        int              cycles;
        logic [DW-1:0]   xtLanes [N];
        logic [N*DW-1:0] xtVec;

        effLen = (len > T_MAX) ? T_MAX : len;
        for (int i = 0; i < M; i++) hModel[i] = '0;
        cModel = 0;

        start  = 1'b1;
        seqLen = T_W'(len);
        @(negedge clk);
        start  = 1'b0;
        seqLen = T_W'($urandom);
        checkOutput("busyAfterStart", 512'(busy), 512'(1));

        for (int t = 0; t < effLen; t++) begin
            inValid = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                checkOutput("loadReady", 512'(inReady), 512'(1));
                @(negedge clk);
            end
            checkOutput("loadReady", 512'(inReady), 512'(1));

            for (int i = 0; i < N; i++)
                xtLanes[i] = (pattern == 1) ? DW'(t + 1) : DW'($urandom);
            for (int i = 0; i < N; i++) xtVec[i*DW +: DW] = xtLanes[i];
            inValid = 1'b1;
            inXt    = xtVec;
            @(negedge clk);

            // Keep a different column pending; it must not be consumed.
            inXt    = ~xtVec;
            inValid = 1'($urandom_range(0, 1));

            if (abortT == t) begin
                rst = 1'b1;
                @(negedge clk);
                rst     = 1'b0;
                inValid = 1'b0;
                checkOutput("abortBusy", 512'(busy), 512'(0));
                checkOutput("abortOutValid", 512'(outValid), 512'(0));
                checkOutput("abortInReady", 512'(inReady), 512'(0));
                checkOutput("abortCellXt", 512'(cellXt), 512'(0));
                checkOutput("abortCellHt", 512'(cellHt), 512'(0));
                checkOutput("abortCellCt", 512'(cellCt), 512'(0));
                checkOutput("abortOutHt", 512'(outHt), 512'(0));
                checkOutput("abortOutT", 512'(outT), 512'(0));
                checkOutput("abortDone", 512'(done), 512'(0));
                @(negedge clk);
                checkOutput("abortNoDone", 512'(done), 512'(0));
                return;
            end

            cycles = 0;
            while (!outValid && cycles <= CELL_LAT + 4) begin
                checkOutput("runCellXt", 512'(cellXt), 512'(xtVec));
                checkOutput("runCellHt", 512'(cellHt), 512'(packHidden()));
                checkOutput("runCellCt", 512'(cellCt), 512'(fillLanes(cModel)));
                checkOutput("runInReady", 512'(inReady), 512'(0));
                @(negedge clk);
                cycles++;
            end
            checkOutput("xtToValidLat", 512'(cycles), 512'(CELL_LAT + 1));
            if (!outValid) begin
                inValid = 1'b0;
                return;
            end

            for (int i = 0; i < M; i++) hModel[i] = hModel[i] + xtLanes[i];
            cModel++;

            stallN   = (stall < 0) ? $urandom_range(0, 3) : stall;
            outReady = 1'b0;
            repeat (stallN) begin
                if (pokeStart) begin
                    start  = 1'b1;
                    seqLen = T_W'(7);
                end
                checkEmit(t, effLen);
                @(negedge clk);
                start = 1'b0;
            end
            outReady = 1'b1;
            checkEmit(t, effLen);
            @(negedge clk);
            outReady = 1'b0;
            inValid  = 1'b0;
        end

        checkOutput("donePulse", 512'(done), 512'(1));
        checkOutput("doneBusy", 512'(busy), 512'(0));
        checkOutput("doneOutValid", 512'(outValid), 512'(0));
        @(negedge clk);
        checkOutput("doneCleared", 512'(done), 512'(0));
    endtask

    // Main sequence of scenarios.
    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        seqLen   = '0;
        inValid  = 1'b0;
        inXt     = '0;
        outReady = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rstBusy", 512'(busy), 512'(0));
        checkOutput("rstDone", 512'(done), 512'(0));
        checkOutput("rstInReady", 512'(inReady), 512'(0));
        checkOutput("rstOutValid", 512'(outValid), 512'(0));
        checkOutput("rstOutHt", 512'(outHt), 512'(0));
        checkOutput("rstOutT", 512'(outT), 512'(0));
        checkOutput("rstOutLast", 512'(outLast), 512'(0));
        checkOutput("rstCellXt", 512'(cellXt), 512'(0));
        checkOutput("rstCellHt", 512'(cellHt), 512'(0));
        checkOutput("rstCellCt", 512'(cellCt), 512'(0));
        rst = 1'b0;
        @(negedge clk);

        // xt offered while idle stays pending.
        inValid = 1'b1;
        inXt    = {16{32'hdeadbeef}};
        @(negedge clk);
        checkOutput("idleInReady", 512'(inReady), 512'(0));
        checkOutput("idleBusy", 512'(busy), 512'(0));
        inValid = 1'b0;

        $display("[TB] three-step sequence with xt elements t+1");
        applyStimulus(3, 1, 0, -1, 1'b0);

        $display("[TB] zero-length sequence");
        start  = 1'b1;
        seqLen = '0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zeroLenDone", 512'(done), 512'(1));
        checkOutput("zeroLenBusy", 512'(busy), 512'(0));
        checkOutput("zeroLenInReady", 512'(inReady), 512'(0));
        checkOutput("zeroLenOutValid", 512'(outValid), 512'(0));
        @(negedge clk);
        checkOutput("zeroLenDoneClr", 512'(done), 512'(0));
        checkOutput("zeroLenBusy2", 512'(busy), 512'(0));

        $display("[TB] back-pressure of five cycles in EMIT");
        applyStimulus(2, 0, 5, -1, 1'b0);

        $display("[TB] reset during RUN of t=1, then a fresh sequence");
        applyStimulus(4, 0, -1, 1, 1'b0);
        applyStimulus(2, 1, -1, -1, 1'b0);

        $display("[TB] start pulsed while busy is ignored");
        applyStimulus(3, 0, 2, -1, 1'b1);
        applyStimulus(2, 1, 0, -1, 1'b0);

        $display("[TB] over-long seq_len clamps to T_MAX");
        applyStimulus(100, 0, 0, -1, 1'b0);

        $display("[TB] random sequences");
        repeat (6) applyStimulus($urandom_range(1, 8), 0, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
